// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode word layout and mode bit positions.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TRANSFER,
    ST_HOLD
  } spi_state_t;

  typedef logic [1:0] spi_mode_t;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake bundle of the SPI master: word in/out, start request, busy/done status.
interface spi_master_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data_in;
  logic                  send;
  spi_mode_t             mode;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_out;

  // master: the host logic issuing requests; slave: the spi_master serving them
  modport master (output data_in, output send, output mode,
                  input busy, input done, input data_out);
  modport slave  (input data_in, input send, input mode,
                  output busy, output done, output data_out);

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer and registered SCK generator; strobes mark leading/trailing SCK edges.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  input  logic toggle,
  input  logic cpol,
  input  logic sck_idle,
  output logic tick,
  output logic lead_stb,
  output logic trail_stb,
  output logic sck
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick      = en && (cnt_q == CW'(CLK_DIV - 1));
  // A toggle away from the idle level is a leading edge
  assign lead_stb  = toggle && tick && (sck == cpol);
  assign trail_stb = toggle && tick && (sck != cpol);

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else begin
      cnt_q <= (!en || tick) ? '0 : cnt_q + CW'(1);
      if (!toggle)
        sck <= sck_idle;
      else if (tick)
        sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: FSM, TX/RX shift registers and SCK edge counter for all four CPOL/CPHA modes.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic             clk,
  input  logic             srst,
  spi_master_if.slave      host,
  output logic             sck,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned EW = $clog2(2 * DATA_WIDTH) + 1;

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, rx_q, data_out_q;
  spi_mode_t             mode_q;
  logic [EW-1:0]         edge_cnt_q;
  logic                  busy_q, done_q;
  logic                  tick, lead_stb, trail_stb;
  logic                  accept, last_edge, sample, shift;
  logic                  gen_en, gen_toggle, gen_idle;

  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign host.data_out = data_out_q;

  assign last_edge  = (edge_cnt_q == EW'(2 * DATA_WIDTH - 1));
  assign gen_en     = (state_q != ST_IDLE);
  assign gen_toggle = (state_q == ST_TRANSFER);
  assign gen_idle   = (state_q == ST_IDLE) ? host.mode[CPOL_BIT] : mode_q[CPOL_BIT];

  // CPHA=0 shifts on trailing edges but not after the final one, so the last bit stays on mosi
  assign sample = mode_q[CPHA_BIT] ? trail_stb : lead_stb;
  assign shift  = mode_q[CPHA_BIT] ? lead_stb  : (trail_stb && !last_edge);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .srst     (srst),
    .en       (gen_en),
    .toggle   (gen_toggle),
    .cpol     (mode_q[CPOL_BIT]),
    .sck_idle (gen_idle),
    .tick     (tick),
    .lead_stb (lead_stb),
    .trail_stb(trail_stb),
    .sck      (sck)
  );

  always_ff @(posedge clk) begin
    if (srst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // the done cycle still blocks a new request
        accept = host.send && !done_q;
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP:    if (tick) state_d = ST_TRANSFER;
      ST_TRANSFER: if (tick && last_edge) state_d = ST_HOLD;
      ST_HOLD:     if (tick) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      mode_q     <= '0;
      edge_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        tx_q       <= host.data_in;
        rx_q       <= '0;
        mode_q     <= host.mode;
        edge_cnt_q <= '0;
        busy_q     <= 1'b1;
        cs         <= 1'b0;
        mosi       <= host.mode[CPHA_BIT] ? 1'b0 : host.data_in[DATA_WIDTH-1];
      end
      if (state_q == ST_TRANSFER && tick)
        edge_cnt_q <= edge_cnt_q + EW'(1);
      if (shift) begin
        tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
        mosi <= mode_q[CPHA_BIT] ? tx_q[DATA_WIDTH-1] : tx_q[DATA_WIDTH-2];
      end
      if (sample)
        rx_q <= {rx_q[DATA_WIDTH-2:0], miso};
      if (state_q == ST_HOLD && tick) begin
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        data_out_q <= rx_q;
        cs         <= 1'b1;
        mosi       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default 8-bit/CLK_DIV=4 instance plus a 16-bit/CLK_DIV=1 instance.
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(8))  h1 ();
  spi_master_if #(.DATA_WIDTH(16)) h2 ();

  logic sck1, cs1, mosi1, miso1;
  logic sck2, cs2, mosi2, miso2;

  logic      loop_en;
  logic      slave_miso;
  spi_mode_t s_mode;
  logic [7:0] s_word;
  int        s_idx;
  logic      s_prev;

  int checks = 0;
  int errors = 0;

  assign miso1 = loop_en ? mosi1 : slave_miso;
  assign miso2 = mosi2;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) u1 (
    .clk(clk), .srst(srst), .host(h1), .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(miso1)
  );

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(1)) u2 (
    .clk(clk), .srst(srst), .host(h2), .sck(sck2), .cs(cs2), .mosi(mosi2), .miso(miso2)
  );

  // Behavioural slave: presents s_word MSB first, changing data on the edge opposite to sampling
  always @(negedge clk) begin
    if (cs1 === 1'b1) begin
      s_idx      = 7;
      slave_miso = s_mode[CPHA_BIT] ? 1'b0 : s_word[7];
    end else if (cs1 === 1'b0 && sck1 !== s_prev) begin
      if (s_mode[CPHA_BIT] == 1'b0) begin
        if (sck1 == s_mode[CPOL_BIT]) begin
          s_idx = s_idx - 1;
          if (s_idx >= 0) slave_miso = s_word[s_idx[2:0]];
        end
      end else if (sck1 != s_mode[CPOL_BIT]) begin
        if (s_idx >= 0) slave_miso = s_word[s_idx[2:0]];
        s_idx = s_idx - 1;
      end
    end
    s_prev = sck1;
  end

  task automatic accept1(input logic [7:0] d, input spi_mode_t m);
    @(negedge clk);
    h1.data_in = d;
    h1.mode    = m;
    h1.send    = 1'b1;
    @(posedge clk);
    #1 h1.send = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs1); end
    checks++; if (sck1 !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck1); end
    checks++; if (mosi1 !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi1); end
    checks++; if (h1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", h1.busy); end
    checks++; if (h1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", h1.done); end
    checks++; if (h1.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", h1.data_out); end
    checks++; if (cs2 !== 1'b1) begin errors++; $display("FAIL reset_cs2: got %b expected 1", cs2); end
    checks++; if (h2.data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out2: got %h expected 0000", h2.data_out); end
    srst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] exp_bits = 8'hA5;
    int busy_cnt = 0, done_cnt = 0, done_cyc = -1, toggles = 0;
    logic prev;
    loop_en = 1'b0; s_mode = 2'd0; s_word = 8'h3C;
    accept1(8'hA5, 2'd0);
    prev = sck1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (cs1 !== 1'b0) begin errors++; $display("FAIL m0_cs_c1: got %b expected 0", cs1); end
        checks++; if (mosi1 !== 1'b1) begin errors++; $display("FAIL m0_mosi_c1: got %b expected 1", mosi1); end
      end
      if (c >= 8 && c <= 64 && (c % 8) == 0) begin
        checks++;
        if (mosi1 !== exp_bits[8 - c / 8]) begin
          errors++; $display("FAIL m0_mosi_bit%0d: got %b expected %b", c / 8 - 1, mosi1, exp_bits[8 - c / 8]);
        end
      end
      if (c == 73) begin
        checks++; if (h1.busy !== 1'b0) begin errors++; $display("FAIL m0_busy_c73: got %b expected 0", h1.busy); end
        checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL m0_cs_c73: got %b expected 1", cs1); end
      end
      if (h1.busy === 1'b1) busy_cnt++;
      if (h1.done === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (sck1 !== prev) toggles++;
      prev = sck1;
    end
    checks++; if (done_cyc != 73) begin errors++; $display("FAIL m0_done_cycle: got %0d expected 73", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL m0_done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_cnt != 72) begin errors++; $display("FAIL m0_busy_cycles: got %0d expected 72", busy_cnt); end
    checks++; if (toggles != 16) begin errors++; $display("FAIL m0_sck_toggles: got %0d expected 16", toggles); end
    checks++; if (h1.data_out !== 8'h3C) begin errors++; $display("FAIL m0_data_out: got %h expected 3c", h1.data_out); end
  endtask

  task automatic test_mode3();
    int falls = 0, rises = 0, done_cnt = 0;
    logic prev;
    logic first_fall = 1'b0;
    loop_en = 1'b0; s_mode = 2'd3; s_word = 8'hFF;
    @(negedge clk); h1.mode = 2'd3;
    repeat (3) @(negedge clk);
    checks++; if (sck1 !== 1'b1) begin errors++; $display("FAIL m3_sck_idle_before: got %b expected 1", sck1); end
    accept1(8'h81, 2'd3);
    prev = sck1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (prev === 1'b1 && sck1 === 1'b0) begin
        if (falls == 0 && rises == 0) first_fall = 1'b1;
        falls++;
      end
      if (prev === 1'b0 && sck1 === 1'b1) rises++;
      if (h1.done === 1'b1) done_cnt++;
      prev = sck1;
    end
    checks++; if (first_fall !== 1'b1) begin errors++; $display("FAIL m3_first_edge_fall: got %b expected 1", first_fall); end
    checks++; if (falls != 8) begin errors++; $display("FAIL m3_falls: got %0d expected 8", falls); end
    checks++; if (rises != 8) begin errors++; $display("FAIL m3_rises: got %0d expected 8", rises); end
    checks++; if (sck1 !== 1'b1) begin errors++; $display("FAIL m3_sck_idle_after: got %b expected 1", sck1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL m3_done_count: got %0d expected 1", done_cnt); end
    checks++; if (h1.data_out !== 8'hFF) begin errors++; $display("FAIL m3_data_out: got %h expected ff", h1.data_out); end
  endtask

  task automatic test_loopback(input spi_mode_t m);
    int done_cnt = 0;
    loop_en = 1'b1;
    @(negedge clk); h1.mode = m;
    repeat (2) @(negedge clk);
    checks++;
    if (sck1 !== m[CPOL_BIT]) begin errors++; $display("FAIL lb%0d_sck_idle: got %b expected %b", m, sck1, m[CPOL_BIT]); end
    accept1(8'h5A, m);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (h1.done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL lb%0d_done_count: got %0d expected 1", m, done_cnt); end
    checks++; if (h1.data_out !== 8'h5A) begin errors++; $display("FAIL lb%0d_data_out: got %h expected 5a", m, h1.data_out); end
    checks++;
    if (sck1 !== m[CPOL_BIT]) begin errors++; $display("FAIL lb%0d_sck_after: got %b expected %b", m, sck1, m[CPOL_BIT]); end
  endtask

  task automatic test_send_ignored();
    int done_cnt = 0;
    loop_en = 1'b1;
    accept1(8'h33, 2'd0);
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      h1.send = (c == 10 || c == 72 || c == 73 || c == 74);
      if (c == 10) begin h1.data_in = 8'hC3; h1.mode = 2'd3; end
      if (h1.done === 1'b1) begin
        done_cnt++;
        checks++;
        if (c != 73 && c != 147) begin errors++; $display("FAIL ign_done_cycle: got %0d expected 73 or 147", c); end
      end
      if (c == 74) begin
        checks++; if (h1.data_out !== 8'h33) begin errors++; $display("FAIL ign_data_out1: got %h expected 33", h1.data_out); end
        checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL ign_cs_gap: got %b expected 1", cs1); end
      end
      if (c == 75) begin
        checks++; if (cs1 !== 1'b0) begin errors++; $display("FAIL ign_cs_c75: got %b expected 0", cs1); end
        checks++; if (h1.busy !== 1'b1) begin errors++; $display("FAIL ign_busy_c75: got %b expected 1", h1.busy); end
      end
    end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL ign_done_count: got %0d expected 2", done_cnt); end
    checks++; if (h1.data_out !== 8'hC3) begin errors++; $display("FAIL ign_data_out2: got %h expected c3", h1.data_out); end
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    loop_en = 1'b1;
    accept1(8'h77, 2'd0);
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (c == 30) srst = 1'b1;
      if (c == 31) begin
        srst = 1'b0;
        checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL abort_cs: got %b expected 1", cs1); end
        checks++; if (sck1 !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b expected 0", sck1); end
        checks++; if (h1.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", h1.busy); end
        checks++; if (h1.data_out !== 8'h00) begin errors++; $display("FAIL abort_data_out: got %h expected 00", h1.data_out); end
      end
      if (h1.done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done_count: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    @(negedge clk);
    h2.data_in = 16'hBEEF; h2.mode = 2'd0; h2.send = 1'b1;
    @(posedge clk);
    #1 h2.send = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 36) begin h2.send = 1'b1; h2.data_in = 16'h1234; end
      if (c == 37) h2.send = 1'b0;
      if (h2.done === 1'b1) done_cnt++;
      if (c == 35) begin
        checks++; if (h2.done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", h2.done); end
        checks++; if (h2.data_out !== 16'hBEEF) begin errors++; $display("FAIL b2b_data1: got %h expected beef", h2.data_out); end
      end
      if (c == 36) begin
        checks++; if (cs2 !== 1'b1) begin errors++; $display("FAIL b2b_cs_gap: got %b expected 1", cs2); end
      end
      if (c == 37) begin
        checks++; if (cs2 !== 1'b0) begin errors++; $display("FAIL b2b_cs_second: got %b expected 0", cs2); end
      end
      if (c == 71) begin
        checks++; if (h2.done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", h2.done); end
        checks++; if (h2.data_out !== 16'h1234) begin errors++; $display("FAIL b2b_data2: got %h expected 1234", h2.data_out); end
      end
    end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
  endtask

  initial begin
    srst = 1'b1;
    h1.data_in = '0; h1.send = 1'b0; h1.mode = 2'd0;
    h2.data_in = '0; h2.send = 1'b0; h2.mode = 2'd0;
    loop_en = 1'b0; s_mode = 2'd0; s_word = 8'h00; s_idx = 7; s_prev = 1'b0; slave_miso = 1'b0;
    test_reset();
    test_mode0();
    test_mode3();
    test_loopback(2'd1);
    test_loopback(2'd2);
    @(negedge clk); h1.mode = 2'd0;
    repeat (2) @(negedge clk);
    test_send_ignored();
    @(negedge clk); h1.mode = 2'd0;
    repeat (2) @(negedge clk);
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that serialises a parallel word onto `mosi` and captures the returned `miso` word. It generates `sck` and `cs` from the system clock. It sits directly upstream of the SPI slave: its `sck`/`cs`/`mosi` drive the slave's pins and it consumes the slave's `miso`. It supports all four CPOL/CPHA modes and uses a start/busy/done handshake toward the host logic.

## Interface
- `DATA_WIDTH`, 8: bits per transaction, ≥2.
- `CLK_DIV`, 4: `clk` cycles per SCK half-period, ≥1.

- `clk`  in  1  system clock, all logic on rising edge.
- `srst`  in  1  reset, synchronous, active-high.
- `data_in`  in  DATA_WIDTH  word to transmit, sampled when a send is accepted.
- `send`  in  1  start request, honoured only in IDLE.
- `mode`  in  2  {CPOL,CPHA}, sampled when a send is accepted.
- `busy`  out  1  high from accept until done, inclusive of neither accept cycle nor done cycle.
- `done`  out  1  one-cycle pulse at transaction end.
- `data_out`  out  DATA_WIDTH  last received word, held until the next done.
- `sck`  out  1  serial clock.
- `cs`  out  1  chip select, active-low.
- `mosi`  out  1  serial data out, MSB first.
- `miso`  in  1  serial data in, MSB first, already synchronous to `clk`.

## Operation
- FSM states: IDLE → SETUP → TRANSFER → HOLD → IDLE.
- **IDLE**
  - `cs`=1, `busy`=0, `mosi`=0.
  - `sck` follows `mode[1]`, registered.
  - When `send`=1, latch `data_in` into the TX shift register and latch `mode`, then go to SETUP.
- **SETUP**
  - One half-period.
  - `cs`=0, `busy`=1, `sck` held at the latched CPOL.
  - If CPHA=0, `mosi` = TX MSB from the first SETUP cycle.
- **TRANSFER**
  - 2·DATA_WIDTH SCK edges, alternating leading and trailing, each after CLK_DIV cycles.
  - CPHA=0: sample `miso` on leading edges; shift the next TX bit onto `mosi` on trailing edges. No shift after the last trailing edge.
  - CPHA=1: drive the next TX bit onto `mosi` on leading edges, starting with the MSB; sample on trailing edges.
  - Sampling shifts `miso` into the RX register LSB end, so the first bit ends up as MSB.
  - Edge counter width is $clog2(2·DATA_WIDTH)+1.
- **HOLD**
  - One half-period, `sck` at the latched CPOL, `cs`=0.
  - On exit:
    - `cs`→1
    - `busy`→0
    - `done`=1 for one cycle
    - `data_out` ← RX register
    - `mosi`→0
- `send` while `busy` is ignored, with no queueing. `mode` and `data_in` changes during a transfer have no effect.
- `send` in the same cycle as `done` is ignored. A new send is accepted from the following cycle.
- `srst` wins over `send`. `srst` mid-transaction aborts in the next cycle with no `done` pulse.
- Reset values: `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `data_out`=0, state IDLE.

## Timing
- The accept edge is cycle 0.
- `cs`=0 and `busy`=1 are visible from cycle 1.
- Cycles spent: SETUP CLK_DIV, TRANSFER 2·DATA_WIDTH·CLK_DIV, HOLD CLK_DIV.
- `done`, `cs`=1 and the new `data_out` appear at cycle 1+(2·DATA_WIDTH+2)·CLK_DIV. Defaults: 73.
- The earliest next accept is that cycle+1, giving the back-to-back `cs`-high gap of ≥1 cycle.
- SCK edge k (k=1..2·DATA_WIDTH) toggles at cycle 1+(k+1)·CLK_DIV. Odd k is a leading edge.
- Sampling uses the `miso` value present in the cycle the edge is registered.
- With CLK_DIV=1, `sck` toggles every cycle, and all rules above still hold.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum
  - `spi_mode_t` (2-bit)
  - constants `CPOL_BIT`=1 and `CPHA_BIT`=0
  - shared with the slave
- Sub-module `spi_clk_gen`: half-period counter with `en`, `lead_stb`, `trail_stb`, and the registered `sck` output, parameterised by CLK_DIV.
- The top level holds the FSM, the TX/RX shift registers and the edge counter.

## Test plan
- Mode 0, defaults, `data_in`=0xA5, behavioural slave returns 0x3C → `mosi` sequence 1,0,1,0,0,1,0,1; `data_out`=0x3C; `done` at cycle 73; `busy` high cycles 1–72.
- Mode 3, `data_in`=0x81, slave returns 0xFF → `sck` idles 1 before and after; 8 falling-then-rising pulses; `data_out`=0xFF.
- Modes 1 and 2, loopback `miso`=`mosi`, `data_in`=0x5A → `data_out`=0x5A in both modes. In mode 2, `sck` idle level is 1.
- `send` pulsed at cycles 10 and 72 of a transfer → both ignored; exactly one `done`. `send` at cycle 74 → accepted, with `cs` low at 75.
- `srst` at cycle 30 → `cs`=1, `sck`=0, `busy`=0 at cycle 31; no `done`; `data_out`=0.
- CLK_DIV=1, DATA_WIDTH=16, back-to-back sends of 0xBEEF / 0x1234 with loopback → each `done` at 1+34 cycles after accept; `data_out` matches each word.
